percept_unit: RTL and testbench

- Parametrised single-neuron perceptron engine; successor to the fixed percept_bank datapath.
- Streams N_IN signed inputs over a valid/ready handshake and computes the weighted sum plus bias with one sequential MAC.
- Outputs a binary class. In train mode it applies the perceptron update rule on misclassification.
- Sits between percept_bank_control (byte framing from uart) and the bank. Also offers an IDLE-only weight-write port for preload.

---
 rtl/percept_unit.sv | 181 ++++++++++++++++++
 tb/tb_percept_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/percept_unit.sv
// percept_unit: single-neuron perceptron with a sequential MAC, train-mode update rule and IDLE-only weight preload.
// Define PERCEPT_SAT_EN to make weight/bias updates saturate; otherwise they wrap two's-complement.
module percept_unit #(
  parameter int N_IN     = 4,
  parameter int DATA_W   = 8,
  parameter int W_W      = 8,
  parameter int LR_SHIFT = 0,
  parameter int ACC_W    = DATA_W + W_W + $clog2(N_IN + 1) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          x_valid,
  input  logic signed [DATA_W-1:0]      x_data,
  output logic                          x_ready,
  input  logic                          train,
  input  logic                          target,
  input  logic                          w_we,
  input  logic [$clog2(N_IN+1)-1:0]     w_addr,
  input  logic signed [W_W-1:0]         w_data,
  output logic                          y_valid,
  output logic                          y,
  output logic signed [ACC_W-1:0]       sum,
  output logic                          updated
);
  localparam int CNT_W  = $clog2(N_IN + 1);
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = DATA_W + W_W;
  localparam int UPD_W  = W_W + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] BIAS_IDX = CNT_W'(N_IN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DECIDE, S_UPDATE, S_DONE} state_e;
  state_e state_q, state_d;

  logic signed [W_W-1:0]    w_q [N_IN];
  logic signed [W_W-1:0]    w_d [N_IN];
  logic signed [DATA_W-1:0] x_q [N_IN];
  logic signed [DATA_W-1:0] x_d [N_IN];
  logic signed [W_W-1:0]    bias_q, bias_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic train_q, train_d, target_q, target_d, upd_q, upd_d;
  logic y_q, y_d, y_valid_q, y_valid_d, updated_q, updated_d;

  logic                     beat, y_int, mismatch;
  logic [IDX_W-1:0]         idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] x_sh;
  logic signed [UPD_W-1:0]  w_upd, b_upd;

  function automatic logic signed [W_W-1:0] narrow(input logic signed [UPD_W-1:0] v);
`ifdef PERCEPT_SAT_EN
    if (v[UPD_W-1:W_W-1] != {3{v[UPD_W-1]}})
      return v[UPD_W-1] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
    return v[W_W-1:0];
`else
    return W_W'(v);
`endif
  endfunction

  assign beat     = x_valid && x_ready;
  assign idx      = cnt_q[IDX_W-1:0];
  assign y_int    = ~acc_q[ACC_W-1];
  assign mismatch = train_q && (y_int != target_q);
  assign prod     = PROD_W'(w_q[idx]) * PROD_W'(x_q[idx]);
  assign x_sh     = x_q[idx] >>> LR_SHIFT;
  assign w_upd    = target_q ? UPD_W'(w_q[idx]) + UPD_W'(x_sh) : UPD_W'(w_q[idx]) - UPD_W'(x_sh);
  assign b_upd    = target_q ? UPD_W'(bias_q) + UPD_W'(1) : UPD_W'(bias_q) - UPD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (beat) state_d = (N_IN == 1) ? S_MAC : S_LOAD;
      S_LOAD:   if (beat && cnt_q == LAST_IDX) state_d = S_MAC;
      S_MAC:    if (cnt_q == LAST_IDX) state_d = S_DECIDE;
      S_DECIDE: state_d = mismatch ? S_UPDATE : S_DONE;
      S_UPDATE: if (cnt_q == BIAS_IDX) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  end

  // NOTE: every _d starts from its _q so no path through this block can infer a latch.
  always_comb begin
    w_d = w_q;  x_d = x_q;  bias_d = bias_q;  acc_d = acc_q;  cnt_d = cnt_q;
    train_d = train_q;  target_d = target_q;  upd_d = upd_q;
    y_d = y_q;  sum_d = sum_q;  updated_d = updated_q;  y_valid_d = 1'b0;

    // A preload write in the same cycle as the first beat lands before any MAC reads it.
    if (state_q == S_IDLE && w_we) begin
      if (w_addr < BIAS_IDX)       w_d[w_addr[IDX_W-1:0]] = w_data;
      else if (w_addr == BIAS_IDX) bias_d = w_data;
    end

    unique case (state_q)
      S_IDLE: if (beat) begin
        x_d[0]   = x_data;
        train_d  = train;
        target_d = target;
        upd_d    = 1'b0;
        cnt_d    = (N_IN == 1) ? '0 : CNT_W'(1);
      end
      S_LOAD: if (beat) begin
        x_d[idx] = x_data;
        cnt_d    = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      end
      S_MAC: begin
        acc_d = ((cnt_q == '0) ? ACC_W'(bias_q) : acc_q) + ACC_W'(prod);
        cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      end
      S_DECIDE: begin
        upd_d = mismatch;
        cnt_d = '0;
      end
      S_UPDATE: begin
        if (cnt_q == BIAS_IDX) begin
          bias_d = narrow(b_upd);
          cnt_d  = '0;
        end else begin
          w_d[idx] = narrow(w_upd);
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        y_valid_d = 1'b1;
        y_d       = y_int;
        sum_d     = acc_q;
        updated_d = upd_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the weight and input arrays are reset too, since a reset must leave a zero-weight neuron.
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      bias_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      train_q   <= 1'b0;
      target_q  <= 1'b0;
      upd_q     <= 1'b0;
      y_q       <= 1'b0;
      sum_q     <= '0;
      updated_q <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      w_q       <= w_d;
      x_q       <= x_d;
      bias_q    <= bias_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      train_q   <= train_d;
      target_q  <= target_d;
      upd_q     <= upd_d;
      y_q       <= y_d;
      sum_q     <= sum_d;
      updated_q <= updated_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign sum     = sum_q;
  assign updated = updated_q;
endmodule

// File: tb/tb_percept_unit.sv
// Scoreboard bench for percept_unit: a plain-arithmetic neuron model predicts each result,
// a negedge monitor pops and compares whenever y_valid is seen.
module tb_percept_unit;
  localparam int N_IN     = 4;
  localparam int DATA_W   = 8;
  localparam int W_W      = 8;
  localparam int LR_SHIFT = 0;
  localparam int ACC_W    = DATA_W + W_W + $clog2(N_IN + 1) + 1;
  localparam int AW       = $clog2(N_IN + 1);

  logic                     clk = 1'b0, rst = 1'b1;
  logic                     x_valid = 1'b0, train = 1'b0, target = 1'b0, w_we = 1'b0;
  logic signed [DATA_W-1:0] x_data = '0;
  logic [AW-1:0]            w_addr = '0;
  logic signed [W_W-1:0]    w_data = '0;
  logic                     x_ready, y_valid, y, updated;
  logic signed [ACC_W-1:0]  sum;

  percept_unit #(.N_IN(N_IN), .DATA_W(DATA_W), .W_W(W_W), .LR_SHIFT(LR_SHIFT)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .train(train), .target(target), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .y_valid(y_valid), .y(y), .sum(sum), .updated(updated)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sum;
    bit     y;
    bit     upd;
    longint hs;
    int     lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0, fails = 0;

  // Reference neuron state
  int mw[N_IN];
  int mb;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int narrow(input int v);
`ifdef PERCEPT_SAT_EN
    if (v > 2 ** (W_W - 1) - 1) return 2 ** (W_W - 1) - 1;
    if (v < -(2 ** (W_W - 1)))  return -(2 ** (W_W - 1));
    return v;
`else
    return ((v + 2 ** (W_W - 1)) & (2 ** W_W - 1)) - 2 ** (W_W - 1);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
    mb = 0;
  endtask

  task automatic model_write(input int wa, input int wd);
    if (wa < N_IN)       mw[wa] = wd;
    else if (wa == N_IN) mb = wd;
  endtask

  // Monitor: every result pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && y_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_y_valid", y_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("y", y, e.y);
        check("sum", sum, e.sum);
        check("updated", updated, e.upd);
        check("latency", cyc - e.hs, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_beat(input int v, output longint hs);
    int g = 0;
    x_valid = 1'b1;
    x_data  = DATA_W'(v);
    while (!x_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!x_ready) check("x_ready_timeout", x_ready, 1'b1);
    hs = cyc + 1;
    @(negedge clk);
    x_valid = 1'b0;
    w_we    = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wr(input int wa, input int wd);
    w_we   = 1'b1;
    w_addr = AW'(wa);
    w_data = W_W'(wd);
    @(negedge clk);
    w_we = 1'b0;
    model_write(wa, wd);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_y_valid", y_valid, 1'b0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic run_op(input int xs[N_IN], input bit tr, input bit tg, input int gap_after,
                        input bit we_first, input int wa, input int wd, input bit abort);
    int     s;
    bit     yy, up;
    longint hs;
    exp_t   ex;
    if (we_first) model_write(wa, wd);
    s = mb;
    for (int i = 0; i < N_IN; i++) s += mw[i] * xs[i];
    yy = (s >= 0);
    up = tr && (yy != tg);
    for (int i = 0; i < N_IN; i++) begin
      if (i == 0) begin
        train  = tr;
        target = tg;
        if (we_first) begin
          w_we = 1'b1; w_addr = AW'(wa); w_data = W_W'(wd);
        end
      end
      if (i == N_IN - 1 && N_IN > 1) begin
        // A write while loading must be ignored by the engine.
        w_we = 1'b1; w_addr = AW'($urandom_range(0, N_IN)); w_data = W_W'($urandom);
      end
      send_beat(xs[i], hs);
      if (i == gap_after) repeat (5) @(negedge clk);
    end
    if (abort) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      repeat (15) @(negedge clk);
    end else begin
      if (up) begin
        for (int i = 0; i < N_IN; i++)
          mw[i] = narrow(mw[i] + (tg ? (xs[i] >>> LR_SHIFT) : -(xs[i] >>> LR_SHIFT)));
        mb = narrow(mb + (tg ? 1 : -1));
      end
      ex.sum = s; ex.y = yy; ex.upd = up; ex.hs = hs;
      ex.lat = up ? 2 * N_IN + 3 : N_IN + 2;
      exp_q.push_back(ex);
      wait_done();
    end
  endtask

  initial begin
    int v[N_IN];
    int r;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_y_valid", y_valid, 1'b0);
    check("reset_y", y, 1'b0);
    check("reset_sum", sum, 0);
    check("reset_updated", updated, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_x_ready", x_ready, 1'b1);

    v = '{1, 2, 3, 4};
    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // zero weights: sum 0, y 1
    run_op(v, 1'b1, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // train toward 0: update
    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // sum -31

    pulse_reset();
    wr(0, -120);
    wr(1, 127);
    v = '{20, 127, 0, 0};
    run_op(v, 1'b1, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // sum 13729, update
    v = '{1, 0, 0, 0};
    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // bias + w0 (saturated or wrapped)
    v = '{0, 1, 0, 0};
    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // bias + w1 = -1

    v = '{1, 2, 3, 4};
    run_op(v, 1'b0, 1'b0, 1, 1'b0, 0, 0, 1'b0);    // 5-cycle stall between beats 2 and 3

    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b1);   // reset during MAC, no result
    v = '{1, 1, 1, 1};
    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b0);   // weights cleared: sum 0

    v = '{7, -3, 100, -128};
    run_op(v, 1'b1, 1'b1, -1, 1'b0, 0, 0, 1'b0);   // already correct: no update
    v = '{0, 0, 0, 0};
    run_op(v, 1'b0, 1'b0, -1, 1'b1, N_IN, 10, 1'b0); // bias write coincident with first beat
    wr(N_IN + 1, 50);                                 // out-of-range address ignored
    run_op(v, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) begin
        r = int'($urandom_range(0, 255)) - 128;
        wr($urandom_range(0, 2 ** AW - 1), r);
      end
      for (int i = 0; i < N_IN; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      run_op(v, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_IN - 2)) : -1,
             1'b0, 0, 0, 1'b0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
